// File: rtl/adder_pkg.sv
// Shared types for the adder checker: default operand width, checker FSM
// states and the layout of one logged mismatch.
package adder_pkg;

  localparam int ADD_W = 4;
  localparam int SUM_W = ADD_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_t;

  // Entry order matches the flat FIFO word {a, b, s, exp}, head field first.
  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] exp;
  } err_entry_t;

endpackage

// File: rtl/adder_chk_fifo.sv
// Single-clock FIFO holding mismatch records; a pop frees a slot in the
// same edge, so push+pop while full succeeds with occupancy unchanged.
module adder_chk_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [AW:0]      wr_d, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + (AW+1)'(1);
      if (rd_en) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adder_chk.sv
// Two-stage checker for an external W-bit adder: stage 1 captures operands
// and returned sum, stage 2 compares against a full-width reference sum.
module adder_chk
  import adder_pkg::*;
#(
  parameter int W     = ADD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             halt_on_err,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_s,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [W-1:0]     err_a,
  output logic [W-1:0]     err_b,
  output logic [W:0]       err_s,
  output logic [W:0]       err_exp,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic             ovf_sticky,
  output logic             halted
);

  localparam int SW    = W + 1;
  localparam int ENT_W = 2 * W + 2 * SW;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  chk_state_t       state_q;
  logic             halted_q;
  logic             vld_p1_q;
  logic [W-1:0]     a_p1_q, b_p1_q;
  logic [SW-1:0]    s_p1_q;
  logic [SW-1:0]    exp_p1;
  logic             chk_p1, match_p1, mis_p1;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d, ovf_q, ovf_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_wdata, fifo_rdata;

  // Stage 1: capture only while running; clr drops the sample in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= in_valid && (state_q == RUN) && !clr;
  end

  always_ff @(posedge clk) begin
    if (in_valid && (state_q == RUN)) begin
      a_p1_q <= in_a;
      b_p1_q <= in_b;
      s_p1_q <= in_s;
    end
  end

  // Stage 2: compare, count, log. Once halted, anything still in stage 1 is dropped.
  assign exp_p1   = {1'b0, a_p1_q} + {1'b0, b_p1_q};
  assign chk_p1   = vld_p1_q && (state_q != HALT) && !clr;
  assign match_p1 = chk_p1 && (s_p1_q == exp_p1);
  assign mis_p1   = chk_p1 && (s_p1_q != exp_p1);

  assign fifo_push  = mis_p1;
  assign fifo_pop   = err_valid && err_ready;
  assign fifo_wdata = {a_p1_q, b_p1_q, s_p1_q, exp_p1};

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    ovf_d  = ovf_q;
    if (clr) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (match_p1) pass_d = sat_inc(pass_q);
      if (mis_p1) begin
        fail_d = sat_inc(fail_q);
        err_d  = 1'b1;
        if (fifo_full && !fifo_pop) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (en) state_q <= RUN;
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (mis_p1 && halt_on_err) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (clr || !en) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  adder_chk_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign err_valid = !fifo_empty;
  assign {err_a, err_b, err_s, err_exp} = fifo_empty ? '0 : fifo_rdata;

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign err_sticky = err_q;
  assign ovf_sticky = ovf_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_adder_chk.sv
// Scoreboard bench for adder_chk: a reference model tracks counters/flags and
// queues the mismatch records the DUT is expected to hold.
module tb_adder_chk;
  import adder_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, halt_on_err = 1'b0, clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [W:0]       in_s = '0;
  logic             err_valid, err_ready = 1'b0;
  logic [W-1:0]     err_a, err_b;
  logic [W:0]       err_s, err_exp;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             err_sticky, ovf_sticky, halted;

  adder_chk #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt_on_err(halt_on_err), .clr(clr),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_s(in_s),
    .err_valid(err_valid), .err_ready(err_ready),
    .err_a(err_a), .err_b(err_b), .err_s(err_s), .err_exp(err_exp),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_sticky(err_sticky), .ovf_sticky(ovf_sticky), .halted(halted)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  err_entry_t sbq[$];
  int         pass_m = 0, fail_m = 0;
  bit         sticky_m = 0, ovf_m = 0, halted_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    pass_m = 0; fail_m = 0; sticky_m = 0; ovf_m = 0; halted_m = 0;
    sbq.delete();
  endtask

  task automatic model_sample(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    logic [4:0] e;
    e = {1'b0, a} + {1'b0, b};
    if (halted_m) return;
    if (s == e) pass_m++;
    else begin
      fail_m++;
      sticky_m = 1;
      if (sbq.size() < DEPTH) sbq.push_back('{a: a, b: b, s: s, exp: e});
      else ovf_m = 1;
      if (halt_on_err) halted_m = 1;
    end
  endtask

  task automatic present(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    in_valid = 1'b1; in_a = a; in_b = b; in_s = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    model_sample(a, b, s);
    present(a, b, s);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pass"},   32'(pass_cnt),   32'(pass_m));
    check({tag, "_fail"},   32'(fail_cnt),   32'(fail_m));
    check({tag, "_sticky"}, 32'(err_sticky), 32'(sticky_m));
    check({tag, "_ovf"},    32'(ovf_sticky), 32'(ovf_m));
    check({tag, "_halted"}, 32'(halted),     32'(halted_m));
    check({tag, "_valid"},  32'(err_valid),  32'(sbq.size() != 0));
  endtask

  task automatic pop_cmp(input string tag);
    err_entry_t e;
    e = (sbq.size() != 0) ? sbq.pop_front() : '0;
    check(tag, 32'({err_a, err_b, err_s, err_exp}), 32'(e));
  endtask

  task automatic drain(input string tag);
    int n, popped;
    n = sbq.size();
    popped = 0;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      if (!err_valid) break;
      pop_cmp({tag, "_entry"});
      popped++;
      err_ready = 1'b1;
      step();
      err_ready = 1'b0;
    end
    check({tag, "_count"}, 32'(popped), 32'(n));
    check({tag, "_empty"}, 32'(err_valid), 32'(0));
    check({tag, "_zero_head"}, 32'({err_a, err_b, err_s, err_exp}), 32'(0));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ra, rb;
    logic [4:0] rs;

    repeat (2) step();
    rst_n = 1'b1;
    check_state("reset");

    en = 1'b1;
    step();
    drive(4'h9, 4'h8, 5'h11);
    step();
    check_state("match");

    drive(4'hF, 4'h1, 5'h00);
    step();
    check_state("mis");
    check("mis_exp", 32'(err_exp), 32'h10);
    drain("mis");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rs = {1'b0, ra} + {1'b0, rb};
        if ($urandom_range(0, 1) == 1) rs = rs ^ 5'($urandom_range(1, 31));
        drive(ra, rb, rs);
      end
      step();
      check_state("rand");
      drain("rand");
    end

    do_clr();
    check_state("clr");

    for (int i = 0; i < 6; i++) drive(4'(i), 4'(i + 3), 5'h1F);
    step();
    check_state("ovf");
    drain("ovf");

    do_clr();
    for (int i = 0; i < DEPTH; i++) drive(4'(i + 1), 4'h2, 5'h00);
    step();
    check_state("full");
    pop_cmp("full_pop");
    model_sample(4'hA, 4'h6, 5'h01);
    present(4'hA, 4'h6, 5'h01);
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    check_state("pushpop");
    drain("pushpop");

    do_clr();
    halt_on_err = 1'b1;
    drive(4'h3, 4'h4, 5'h00);
    drive(4'h1, 4'h1, 5'h02);
    drive(4'h2, 4'h2, 5'h04);
    drive(4'h7, 4'h7, 5'h0E);
    step();
    check_state("halt");
    do_clr();
    check_state("halt_clr");
    halt_on_err = 1'b0;
    step();

    en = 1'b0;
    step();
    present(4'h1, 4'h1, 5'h02);
    repeat (2) step();
    check_state("idle");
    en = 1'b1;
    step();

    in_valid = 1'b1; in_a = 4'h9; in_b = 4'h8; in_s = 5'h00;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    repeat (3) step();
    check_state("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
